nco_cfg_sched: RTL and testbench

Sequences and shares the NCO configuration port (we / reg_select / data / ce / sclr) in the Costas-loop PLL.
- After start, programs the initial phase increment and phase offset, pulses a synchronous clear, then keeps the NCO clock-enabled.
- While running, arbitrates between two requesters that rewrite NCO registers: the loop-filter frequency update and a phase-offset update.
- Sits between the PLL top-level control and the NCO core.

---
 rtl/nco_cfg_pkg.sv | 33 +++
 rtl/nco_cfg_sched_rr_arb2.sv | 32 +++
 rtl/nco_cfg_sched.sv | 151 +++++++++++++++
 tb/tb_nco_cfg_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nco_cfg_pkg.sv
// Shared encodings and defaults for the NCO configuration scheduler.
package nco_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INIT_F  = 4'd1,
        ST_GAP_F   = 4'd2,
        ST_INIT_P  = 4'd3,
        ST_GAP_P   = 4'd4,
        ST_CLR     = 4'd5,
        ST_RUN     = 4'd6,
        ST_RUN_WR  = 4'd7,
        ST_RUN_GAP = 4'd8
    } state_t;

    localparam logic REG_SEL_FREQ  = 1'b0;
    localparam logic REG_SEL_PHASE = 1'b1;

    localparam logic [31:0] FREQ_INIT_DEF  = 32'h2000_0000;
    localparam logic [31:0] PHASE_INIT_DEF = 32'h9000_0000;

    function automatic logic [31:0] clamp_u32(input logic [31:0] v,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/nco_cfg_sched_rr_arb2.sv
// Two-way round-robin arbiter; ready[0] = frequency, ready[1] = phase.
// One ready is always high while enabled, so requesters see a stable target.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] ready
);

    logic last_grant;  // 1 = phase won last
    logic pick_ph;

    // Lone requester wins; on a tie or with no request, favour the one not granted last.
    always_comb begin
        pick_ph = 1'b0;
        if (req[1] && !req[0])
            pick_ph = 1'b1;
        else if (req[0] == req[1])
            pick_ph = !last_grant;
    end

    assign ready = en ? (pick_ph ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (|(ready & req))
            last_grant <= pick_ph;
    end

endmodule

// File: rtl/nco_cfg_sched.sv
// Sequences NCO start-up programming and arbitrates run-time register rewrites.
module nco_cfg_sched
    import nco_cfg_pkg::*;
#(
    parameter logic [31:0] FREQ_INIT  = FREQ_INIT_DEF,
    parameter logic [31:0] PHASE_INIT = PHASE_INIT_DEF,
    parameter logic [31:0] FREQ_MIN   = 32'h1000_0000,
    parameter logic [31:0] FREQ_MAX   = 32'h3000_0000,
    parameter int          WR_GAP     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        frq_valid,
    input  logic [31:0] frq_data,
    output logic        frq_ready,
    input  logic        ph_valid,
    input  logic [31:0] ph_data,
    output logic        ph_ready,
    output logic        nco_we,
    output logic        nco_reg_select,
    output logic [31:0] nco_data,
    output logic        nco_ce,
    output logic        nco_sclr,
    output logic        running,
    output logic [15:0] clamp_cnt
);

    localparam logic [2:0] GAP = 3'(WR_GAP);

    state_t      state;
    logic [2:0]  gap_cnt;
    logic [1:0]  rdy;
    logic        grant_f;
    logic        grant_p;
    logic [31:0] frq_clamped;
    logic        frq_clip;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state == ST_RUN && !stop),
        .req   ({ph_valid, frq_valid}),
        .ready (rdy)
    );

    assign frq_ready   = rdy[0];
    assign ph_ready    = rdy[1];
    assign grant_f     = frq_valid && frq_ready;
    assign grant_p     = ph_valid && ph_ready;
    assign frq_clamped = clamp_u32(frq_data, FREQ_MIN, FREQ_MAX);
    assign frq_clip    = (frq_data < FREQ_MIN) || (frq_data > FREQ_MAX);

    // Outputs are set on the transition into a state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            gap_cnt        <= 3'd0;
            nco_we         <= 1'b0;
            nco_reg_select <= 1'b0;
            nco_data       <= 32'd0;
            nco_ce         <= 1'b0;
            nco_sclr       <= 1'b0;
            running        <= 1'b0;
            clamp_cnt      <= 16'd0;
        end else begin
            nco_we   <= 1'b0;
            nco_sclr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_INIT_F;
                        nco_we         <= 1'b1;
                        nco_reg_select <= REG_SEL_FREQ;
                        nco_data       <= FREQ_INIT;
                        clamp_cnt      <= 16'd0;
                    end
                end
                ST_INIT_F, ST_GAP_F: begin
                    if (state == ST_INIT_F && GAP != 3'd0) begin
                        state   <= ST_GAP_F;
                        gap_cnt <= GAP - 3'd1;
                    end else if (state == ST_GAP_F && gap_cnt != 3'd0) begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end else begin
                        state          <= ST_INIT_P;
                        nco_we         <= 1'b1;
                        nco_reg_select <= REG_SEL_PHASE;
                        nco_data       <= PHASE_INIT;
                    end
                end
                ST_INIT_P, ST_GAP_P: begin
                    if (state == ST_INIT_P && GAP != 3'd0) begin
                        state   <= ST_GAP_P;
                        gap_cnt <= GAP - 3'd1;
                    end else if (state == ST_GAP_P && gap_cnt != 3'd0) begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end else begin
                        state    <= ST_CLR;
                        nco_ce   <= 1'b1;
                        nco_sclr <= 1'b1;
                    end
                end
                ST_CLR: begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                end
                ST_RUN: begin
                    if (grant_f || grant_p) begin
                        state  <= ST_RUN_WR;
                        nco_we <= 1'b1;
                        if (grant_f) begin
                            nco_reg_select <= REG_SEL_FREQ;
                            nco_data       <= frq_clamped;
                            if (frq_clip && clamp_cnt != 16'hFFFF)
                                clamp_cnt <= clamp_cnt + 16'd1;
                        end else begin
                            nco_reg_select <= REG_SEL_PHASE;
                            nco_data       <= ph_data;
                        end
                    end else if (stop) begin
                        state   <= ST_IDLE;
                        nco_ce  <= 1'b0;
                        running <= 1'b0;
                    end
                end
                ST_RUN_WR, ST_RUN_GAP: begin
                    if (state == ST_RUN_WR && GAP != 3'd0) begin
                        state   <= ST_RUN_GAP;
                        gap_cnt <= GAP - 3'd1;
                    end else if (state == ST_RUN_GAP && gap_cnt != 3'd0) begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end else if (stop) begin
                        state   <= ST_IDLE;
                        nco_ce  <= 1'b0;
                        running <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    nco_ce  <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_cfg_sched.sv
// Directed bench for nco_cfg_sched with default parameters (WR_GAP=1).
module tb_nco_cfg_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        frq_valid = 1'b0;
    logic [31:0] frq_data = 32'd0;
    logic        frq_ready;
    logic        ph_valid = 1'b0;
    logic [31:0] ph_data = 32'd0;
    logic        ph_ready;
    logic        nco_we;
    logic        nco_reg_select;
    logic [31:0] nco_data;
    logic        nco_ce;
    logic        nco_sclr;
    logic        running;
    logic [15:0] clamp_cnt;

    int n_chk = 0;
    int n_err = 0;

    nco_cfg_sched dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .frq_valid      (frq_valid),
        .frq_data       (frq_data),
        .frq_ready      (frq_ready),
        .ph_valid       (ph_valid),
        .ph_data        (ph_data),
        .ph_ready       (ph_ready),
        .nco_we         (nco_we),
        .nco_reg_select (nco_reg_select),
        .nco_data       (nco_data),
        .nco_ce         (nco_ce),
        .nco_sclr       (nco_sclr),
        .running        (running),
        .clamp_cnt      (clamp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, wait (bounded) for its ready, then leave us at the RUN_WR sample point.
    task automatic send(input bit ph, input logic [31:0] d);
        int n;
        n = 0;
        if (ph) begin ph_valid = 1'b1; ph_data = d; end
        else    begin frq_valid = 1'b1; frq_data = d; end
        #1;
        while (!(ph ? ph_ready : frq_ready) && n < 20) begin
            tick();
            n++;
        end
        chk("send_ready", {31'd0, ph ? ph_ready : frq_ready}, 32'd1);
        tick();
        frq_valid = 1'b0;
        ph_valid  = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic sel, input logic [31:0] d);
        chk({tag, "_we"},   {31'd0, nco_we}, 32'd1);
        chk({tag, "_sel"},  {31'd0, nco_reg_select}, {31'd0, sel});
        chk({tag, "_data"}, nco_data, d);
    endtask

    initial begin
        int g;
        int last_cyc;
        logic [31:0] exp_d;

        // 1: reset, then init sequence
        tick(); tick(); tick();
        chk("rst_we", {31'd0, nco_we}, 32'd0);
        chk("rst_data", nco_data, 32'd0);
        chk("rst_ce_sclr_run", {29'd0, nco_ce, nco_sclr, running}, 32'd0);
        chk("rst_ready", {30'd0, frq_ready, ph_ready}, 32'd0);
        chk("rst_clamp", {16'd0, clamp_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_wr("init_f", 1'b0, 32'h2000_0000);
        chk("init_f_run", {31'd0, running}, 32'd0);
        tick();
        chk("gap_f_we", {31'd0, nco_we}, 32'd0);
        chk("gap_f_hold", nco_data, 32'h2000_0000);
        tick();
        chk_wr("init_p", 1'b1, 32'h9000_0000);
        tick();
        chk("gap_p_we", {31'd0, nco_we}, 32'd0);
        tick();
        chk("clr_ce_sclr", {30'd0, nco_ce, nco_sclr}, 32'd3);
        chk("clr_run", {31'd0, running}, 32'd0);
        tick();
        chk("run_flags", {29'd0, nco_ce, nco_sclr, running}, 32'h5);
        chk("run_idle_rdy", {30'd0, ph_ready, frq_ready}, 32'd1);

        // 2: in-range frequency word
        send(1'b0, 32'h2800_0000);
        chk_wr("f_ok", 1'b0, 32'h2800_0000);
        chk("f_ok_clamp", {16'd0, clamp_cnt}, 32'd0);
        chk("f_ok_wr_rdy", {30'd0, ph_ready, frq_ready}, 32'd0);
        tick();
        chk("f_ok_gap_ce", {31'd0, nco_ce}, 32'd1);
        tick();
        chk("rr_idle_rdy", {30'd0, ph_ready, frq_ready}, 32'd2);

        // 3: clamping, including exact bounds
        send(1'b0, 32'h0500_0000);
        chk_wr("f_lo", 1'b0, 32'h1000_0000);
        chk("f_lo_clamp", {16'd0, clamp_cnt}, 32'd1);
        send(1'b0, 32'hF000_0000);
        chk_wr("f_hi", 1'b0, 32'h3000_0000);
        chk("f_hi_clamp", {16'd0, clamp_cnt}, 32'd2);
        send(1'b0, 32'h1000_0000);
        chk_wr("f_min", 1'b0, 32'h1000_0000);
        send(1'b0, 32'h3000_0000);
        chk_wr("f_max", 1'b0, 32'h3000_0000);
        chk("f_edge_clamp", {16'd0, clamp_cnt}, 32'd2);
        send(1'b1, 32'hA5A5_0001);
        chk_wr("ph_pass", 1'b1, 32'hA5A5_0001);
        chk("ph_clamp", {16'd0, clamp_cnt}, 32'd2);

        // 4: both held valid -> F,P,F,P... with writes 3 cycles apart
        frq_valid = 1'b1; frq_data = 32'h2400_0000;
        ph_valid  = 1'b1; ph_data  = 32'h0BAD_F00D;
        g = 0;
        last_cyc = 0;
        for (int c = 1; c <= 40 && g < 8; c++) begin
            tick();
            if (nco_we) begin
                exp_d = (g % 2 == 1) ? 32'h0BAD_F00D : 32'h2400_0000;
                chk("rr_sel", {31'd0, nco_reg_select}, (g % 2 == 1) ? 32'd1 : 32'd0);
                chk("rr_data", nco_data, exp_d);
                if (g > 0)
                    chk("rr_spacing", c - last_cyc, 32'd3);
                last_cyc = c;
                g++;
                if (g == 8) begin
                    frq_valid = 1'b0;
                    ph_valid  = 1'b0;
                end
            end
        end
        chk("rr_grants", g, 32'd8);
        frq_valid = 1'b0;
        ph_valid  = 1'b0;

        // 5: stop during RUN_WR
        send(1'b0, 32'h2000_0004);
        stop = 1'b1;
        chk_wr("stop_wr", 1'b0, 32'h2000_0004);
        tick();
        chk("stop_gap", {30'd0, nco_ce, running}, 32'd3);
        tick();
        chk("stop_idle", {30'd0, nco_ce, running}, 32'd0);
        frq_valid = 1'b1;
        ph_valid  = 1'b1;
        tick();
        tick();
        chk("stop_no_rdy", {30'd0, ph_ready, frq_ready}, 32'd0);
        chk("stop_no_we", {31'd0, nco_we}, 32'd0);
        frq_valid = 1'b0;
        ph_valid  = 1'b0;
        stop = 1'b0;

        // 6: restart clears clamp_cnt, then rst during GAP_P
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_wr("re_init_f", 1'b0, 32'h2000_0000);
        chk("re_clamp", {16'd0, clamp_cnt}, 32'd0);
        tick();
        tick();
        chk_wr("re_init_p", 1'b1, 32'h9000_0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_we_sel", {30'd0, nco_we, nco_reg_select}, 32'd0);
        chk("abort_data", nco_data, 32'd0);
        chk("abort_flags", {29'd0, nco_ce, nco_sclr, running}, 32'd0);

        // fresh start; stray start and stop during init are ignored
        start = 1'b1;
        tick();
        chk_wr("fresh_init_f", 1'b0, 32'h2000_0000);
        stop = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_start_we", {31'd0, nco_we}, 32'd0);
        tick();
        chk_wr("ign_init_p", 1'b1, 32'h9000_0000);
        tick();
        tick();
        stop = 1'b0;
        chk("ign_clr", {30'd0, nco_ce, nco_sclr}, 32'd3);
        tick();
        chk("ign_run", {31'd0, running}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
